// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with valid/ready on request and result sides.
// Define SEQ_DIV_SIGNED_EN to honour is_signed (two's-complement division).
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // valid never waits on ready, and data is held stable while valid is high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz_out;

    logic             w_accept;
    logic             w_last;
    logic             w_dbz;
    logic             w_ovf;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_fix_quo;
    logic [WIDTH-1:0] w_fix_rem;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_dbz    = (divisor == '0);

`ifdef SEQ_DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_a_neg;
    logic w_b_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_neg = is_signed && dividend[WIDTH-1];
    assign w_b_neg = is_signed && divisor[WIDTH-1];
    assign w_abs_a = w_a_neg ? (~dividend + 1'b1) : dividend;
    assign w_abs_b = w_b_neg ? (~divisor + 1'b1) : divisor;
    assign w_ovf   = is_signed && (dividend == MIN_NEG) && (divisor == '1);

    // Special results are preloaded already in final form, so their sign flags stay clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= !(w_dbz || w_ovf) && (w_a_neg ^ w_b_neg);
            r_neg_r <= !(w_dbz || w_ovf) && w_a_neg;
        end
    end

    assign w_fix_quo = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_fix_rem = r_neg_r ? (~r_rem + 1'b1) : r_rem;
`else
    logic w_unused_is_signed;

    assign w_unused_is_signed = is_signed;
    assign w_abs_a   = dividend;
    assign w_abs_b   = divisor;
    assign w_ovf     = 1'b0;
    assign w_fix_quo = r_quo;
    assign w_fix_rem = r_rem;
`endif

    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = {1'b0, w_shift} - {2'b00, r_div};
    assign w_borrow = w_trial[WIDTH+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_BUSY;
            end
            S_BUSY: begin
                if (r_cnt == '0) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A counter of zero marks the result-commit cycle; special cases enter BUSY with it
    // already zero so their result appears one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz_out   <= 1'b0;
        end else if (w_accept) begin
            r_div <= w_abs_b;
            if (w_dbz) begin
                r_quo <= '1;
                r_rem <= dividend;
                r_cnt <= '0;
                r_dbz <= 1'b1;
            end else if (w_ovf) begin
                r_quo <= dividend;
                r_rem <= '0;
                r_cnt <= '0;
                r_dbz <= 1'b0;
            end else begin
                r_quo <= w_abs_a;
                r_rem <= '0;
                r_cnt <= CW'(WIDTH);
                r_dbz <= 1'b0;
            end
        end else if (r_state == S_BUSY) begin
            if (r_cnt != '0) begin
                r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
                r_cnt <= r_cnt - CW'(1);
            end else if (w_last) begin
                r_quotient  <= w_fix_quo;
                r_remainder <= w_fix_rem;
                r_dbz_out   <= r_dbz;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz_out;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases, reset-in-flight, then random traffic.
module tb_seq_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_exp;
  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model: {div_by_zero, quotient, remainder} from plain arithmetic
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    int sa;
    int sb;
    sa = 0;
    sb = 0;
    if (b == 0) return {1'b1, {W{1'b1}}, a};
    q = a / b;
    r = a % b;
`ifdef SEQ_DIV_SIGNED_EN
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
`else
    if (s) sa = 1;
`endif
    return {1'b0, q, r};
  endfunction

  function automatic bit is_special(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bit sp;
    sp = (b == 0);
`ifdef SEQ_DIV_SIGNED_EN
    if (s && a == 16'h8000 && b == 16'hFFFF) sp = 1'b1;
`else
    if (s) sp = sp;
`endif
    return sp;
  endfunction

  // monitor: pops and compares on every result handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", {div_by_zero, quotient, remainder});
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {div_by_zero, quotient, remainder}, mon_exp);
      end
    end
  end

  // driver: one request, wait for result, hold backpressure, then release
  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int hold);
    logic [2*W:0] e;
    int lat;
    int exp_lat;
    e = model(a, b, s);
    exp_lat = is_special(a, b, s) ? 1 : W + 1;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    is_signed = s;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    is_signed = 1'($urandom_range(0, 1));
    check("busy_in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", {div_by_zero, quotient, remainder}, e);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int sel;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", {div_by_zero, quotient, remainder}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_req(16'd100, 16'd7, 1'b0, 0);
    run_req(16'hFFFF, 16'd1, 1'b0, 1);
    run_req(16'd1234, 16'd0, 1'b0, 0);
    run_req(16'd1234, 16'd0, 1'b1, 0);
    run_req(16'hFFF9, 16'd2, 1'b1, 0);
    run_req(16'd7, 16'hFFFE, 1'b1, 0);
    run_req(16'hFFF9, 16'hFFFE, 1'b1, 0);
    run_req(16'h8000, 16'hFFFF, 1'b1, 0);
    run_req(16'h8000, 16'hFFFF, 1'b0, 0);
    run_req(16'd5000, 16'd3, 1'b0, 5);

    // reset while busy: the in-flight operation must vanish
    in_valid = 1'b1;
    dividend = 16'd100;
    divisor = 16'd7;
    is_signed = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_result", {div_by_zero, quotient, remainder}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("no_stale_valid", seen, 0);
    run_req(16'd100, 16'd7, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      a = W'($urandom);
      if (sel == 0) b = '0;
      else if (sel < 4) b = W'($urandom_range(1, 15));
      else if (sel == 4) b = 16'hFFFF;
      else b = W'($urandom);
      if (sel == 5) begin
        a = 16'h8000;
        b = 16'hFFFF;
      end
      run_req(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
